// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART-to-inst_mem program loader.
package prog_loader_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned MAX_WORDS = 256;
    localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CNT   = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_e;

    // States in which a UART byte may be consumed; also where the idle timer runs.
    function automatic logic takes_byte(input state_e s);
        return (s == CNT) || (s == HI) || (s == LO) || (s == CSUM);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and flags
// the cycle in which TIMEOUT_CYC idle cycles will have elapsed.
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned TO_W        = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TO_W-1:0] cnt_q;

    assign expired_o = en_i && (cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: assembles UART bytes into 16-bit words, writes inst_mem and
// holds the CPU until a full image is loaded. Optional macro: LOADER_CSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR   = 8'h00,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned TO_W        = 20
) (
    input  logic              clk_50MHz,
    input  logic              reset_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    output logic [7:0]        mem_addr,
    output logic [WORD_W-1:0] mem_data,
    output logic              mem_wren,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              err
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic [7:0]          mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_data_q, mem_data_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                load_done_q, load_done_d;
    logic                err_q, err_d;
    logic                rx_ready_q;
    logic                mem_wren_q;
`ifdef LOADER_CSUM_EN
    logic [BYTE_W-1:0]   csum_q, csum_d;
`endif

    logic accept;
    logic to_expired;

    assign accept = rx_valid && rx_ready_q;

    loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_timeout (
        .clk_i     (clk_50MHz),
        .rst_i     (reset_n),
        .clr_i     (accept || !rx_ready_q),
        .en_i      (rx_ready_q),
        .expired_o (to_expired)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        hi_d        = hi_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        word_cnt_d  = word_cnt_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = load_done_q;
        err_d       = err_q;
`ifdef LOADER_CSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d     = CNT;
                    word_cnt_d  = '0;
                    load_done_d = 1'b0;
                    err_d       = 1'b0;
                    mem_addr_d  = BASE_ADDR;
                    cpu_hold_d  = 1'b1;
`ifdef LOADER_CSUM_EN
                    csum_d      = '0;
`endif
                end
            end
            CNT: begin
                if (accept) begin
                    remaining_d = (rx_data == '0) ? CNT_W'(MAX_WORDS) : CNT_W'(rx_data);
                    state_d     = HI;
                end
            end
            HI: begin
                if (accept) begin
                    hi_d    = rx_data;
`ifdef LOADER_CSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                    state_d = LO;
                end
            end
            LO: begin
                if (accept) begin
                    mem_data_d = {hi_q, rx_data};
`ifdef LOADER_CSUM_EN
                    csum_d     = csum_q ^ rx_data;
`endif
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                mem_addr_d  = mem_addr_q + 8'd1;
                word_cnt_d  = word_cnt_q + CNT_W'(1);
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q > CNT_W'(1)) begin
                    state_d = HI;
                end else begin
`ifdef LOADER_CSUM_EN
                    state_d     = CSUM;
`else
                    state_d     = DONE;
                    load_done_d = 1'b1;
                    cpu_hold_d  = 1'b0;
`endif
                end
            end
`ifdef LOADER_CSUM_EN
            CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        state_d    = ERR;
                        err_d      = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase

        // An accepted byte in the expiry cycle wins; the timer only runs while waiting.
        if (to_expired && !accept) begin
            state_d    = ERR;
            err_d      = 1'b1;
            cpu_hold_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            hi_q        <= '0;
            mem_addr_q  <= BASE_ADDR;
            mem_data_q  <= '0;
            word_cnt_q  <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            rx_ready_q  <= 1'b0;
            mem_wren_q  <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            hi_q        <= hi_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            word_cnt_q  <= word_cnt_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
            rx_ready_q  <= takes_byte(state_d);
            mem_wren_q  <= (state_d == WRITE);
`ifdef LOADER_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_wren  = mem_wren_q;
    assign word_cnt  = word_cnt_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame table plus reset, wrap, timeout and
// start-handling sequences. Follows LOADER_CSUM_EN if defined.
module tb_prog_loader;

    localparam int unsigned TO_CYC = 40;
    localparam int unsigned NF     = 4;

    logic        clk = 1'b0;
    logic        reset_n, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, mem_wren, cpu_hold, load_done, err;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic [8:0]  word_cnt;

    always #5 clk = ~clk;

    prog_loader #(
        .BASE_ADDR   (8'h00),
        .TIMEOUT_CYC (TO_CYC),
        .TO_W        (6)
    ) dut (
        .clk_50MHz (clk),
        .reset_n   (reset_n),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wren  (mem_wren),
        .word_cnt  (word_cnt),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .err       (err)
    );

    int unsigned nvec  = 0;
    int unsigned nfail = 0;
    logic [23:0] expq[$];

    typedef struct {
        int unsigned      nb;
        logic [0:7][7:0]  b;
        int unsigned      nw;
        logic [0:2][23:0] w;
        logic             done;
        logic             e;
    } frame_t;

    frame_t tbl [NF];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    // Write scoreboard: every mem_wren pulse must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (mem_wren === 1'b1) begin
            if (expq.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, required no write", mem_addr, mem_data);
            end else begin
                chk("mem_write", {8'h00, mem_addr, mem_data}, {8'h00, expq.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                rx_valid = 1'b0;
                return;
            end
        end
        nvec++;
        nfail++;
        $display("FAIL send_timeout: byte %0h not accepted within 100 cycles, required acceptance", b);
        rx_valid = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 20; i++) begin
            if (load_done || err) return;
            @(posedge clk);
            #1;
        end
        nvec++;
        nfail++;
        $display("FAIL wait_end: load_done=%0b err=%0b after 20 cycles, required one set", load_done, err);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] x;
        logic [7:0] bi;

        tbl[0] = '{nb: 5, b: {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00},
                   nw: 2, w: {24'h001234, 24'h01ABCD, 24'h0}, done: 1'b1, e: 1'b0};
        tbl[1] = '{nb: 3, b: {8'h01, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   nw: 1, w: {24'h00BEEF, 24'h0, 24'h0}, done: 1'b1, e: 1'b0};
        tbl[2] = '{nb: 7, b: {8'h03, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00},
                   nw: 3, w: {24'h000001, 24'h01FFFF, 24'h028000}, done: 1'b1, e: 1'b0};
`ifdef LOADER_CSUM_EN
        tbl[0].nb = 6; tbl[0].b[5] = 8'h40;
        tbl[1].nb = 4; tbl[1].b[3] = 8'h51;
        tbl[2].nb = 8; tbl[2].b[7] = 8'h81;
        tbl[3] = '{nb: 6, b: {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, 8'h00, 8'h00},
                   nw: 2, w: {24'h001234, 24'h01ABCD, 24'h0}, done: 1'b0, e: 1'b1};
`else
        tbl[3] = '{nb: 5, b: {8'h02, 8'h5A, 8'hA5, 8'hC3, 8'h3C, 8'h00, 8'h00, 8'h00},
                   nw: 2, w: {24'h005AA5, 24'h01C33C, 24'h0}, done: 1'b1, e: 1'b0};
`endif

        reset_n  = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_mem_wren", mem_wren, 0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_load_done", load_done, 0);
        chk("rst_err", err, 0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;

        // Start and a byte together in IDLE: start wins, the byte waits for CNT.
        rx_valid = 1'b1;
        rx_data  = 8'h02;
        start_pulse();
        chk("start_rx_ready", rx_ready, 1);
        chk("start_word_cnt", word_cnt, 0);
        rx_valid = 1'b0;
        reset_n  = 1'b1;
        @(posedge clk);
        #1;
        reset_n  = 1'b0;

        for (int f = 0; f < NF; f++) begin
            start_pulse();
            for (int j = 0; j < tbl[f].nw; j++) expq.push_back(tbl[f].w[j]);
            for (int k = 0; k < tbl[f].nb; k++) begin
                send(tbl[f].b[k]);
                if (k >= 2 && (k % 2) == 0 && k <= 2 * tbl[f].nw) begin
                    chk("wren_after_lo", mem_wren, 1);
                    chk("ready_in_write", rx_ready, 0);
                end
            end
            wait_end();
            chk("frame_word_cnt", word_cnt, tbl[f].nw);
            chk("frame_mem_addr", mem_addr, tbl[f].nw);
            chk("frame_load_done", load_done, tbl[f].done);
            chk("frame_err", err, tbl[f].e);
            chk("frame_cpu_hold", cpu_hold, !tbl[f].done);
            chk("frame_writes_left", expq.size(), 0);
        end

        // COUNT=00: 256 words, address wraps back to BASE_ADDR.
        start_pulse();
        x = 8'h00;
        for (int i = 0; i < 256; i++) begin
            bi = 8'(i);
            expq.push_back({bi, bi, ~bi});
        end
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            bi = 8'(i);
            send(bi);
            send(~bi);
            x = x ^ bi ^ ~bi;
        end
`ifdef LOADER_CSUM_EN
        send(x);
`endif
        wait_end();
        chk("c0_word_cnt", word_cnt, 256);
        chk("c0_addr_wrap", mem_addr, 8'h00);
        chk("c0_load_done", load_done, 1);
        chk("c0_writes_left", expq.size(), 0);

        // No timeout while sitting in DONE.
        repeat (TO_CYC + 10) @(posedge clk);
        #1;
        chk("done_no_timeout_err", err, 0);
        chk("done_still_done", load_done, 1);
        chk("done_cpu_hold", cpu_hold, 0);

        // Reset after the first WRITE of a load.
        start_pulse();
        expq.push_back(24'h001234);
        send(8'h02);
        send(8'h12);
        send(8'h34);
        @(posedge clk);
        #1;
        chk("mid_word_cnt", word_cnt, 1);
        chk("mid_mem_addr", mem_addr, 8'h01);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        chk("mid_rst_rx_ready", rx_ready, 0);
        chk("mid_rst_mem_wren", mem_wren, 0);
        chk("mid_rst_mem_addr", mem_addr, 8'h00);
        chk("mid_rst_mem_data", mem_data, 0);
        chk("mid_rst_word_cnt", word_cnt, 0);
        chk("mid_rst_cpu_hold", cpu_hold, 1);
        chk("mid_rst_load_done", load_done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_writes_left", expq.size(), 0);

        // Start during HI is ignored.
        start_pulse();
        expq.push_back(24'h00BEEF);
        send(8'h01);
        start_pulse();
        send(8'hBE);
        send(8'hEF);
`ifdef LOADER_CSUM_EN
        send(8'h51);
`endif
        wait_end();
        chk("hi_start_word_cnt", word_cnt, 1);
        chk("hi_start_done", load_done, 1);
        chk("hi_start_err", err, 0);

        // Inter-byte timeout after the high byte; no write may occur.
        start_pulse();
        send(8'h01);
        send(8'h55);
        repeat (TO_CYC - 1) @(posedge clk);
        #1;
        chk("to_not_early", err, 0);
        @(posedge clk);
        #1;
        chk("to_err", err, 1);
        chk("to_cpu_hold", cpu_hold, 1);
        chk("to_rx_ready", rx_ready, 0);
        chk("to_load_done", load_done, 0);

        // Restart from ERR.
        start_pulse();
        chk("err_restart_word_cnt", word_cnt, 0);
        chk("err_restart_err", err, 0);
        chk("err_restart_cpu_hold", cpu_hold, 1);
        chk("err_restart_rx_ready", rx_ready, 1);
        chk("err_restart_addr", mem_addr, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
